// File: rtl/data_memory.sv
// data_memory: byte-addressable word memory with sub-word stores, registered reads and a debug port.
// Define DATA_MEMORY_CLEAR_EN to zero the whole array after reset (o_busy high while clearing).
module data_memory #(
   parameter int BITS_SIZE      = 32,
   parameter int BITS_EXTENSION = 2,
   parameter int BITS_ADDR      = 8,
   parameter int MEM_DEPTH      = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_mem_write,
   input  logic                  i_mem_read,
   input  logic [BITS_ADDR-1:0]  i_addr,
   input  logic [BITS_SIZE-1:0]  i_dato_to_write,
   input  logic [BITS_EXTENSION-1:0] i_ctl_select,
   input  logic [BITS_ADDR-3:0]  i_debug_addr,
   output logic [BITS_SIZE-1:0]  o_dato_read,
   output logic [BITS_SIZE-1:0]  o_debug_dato,
   output logic                  o_busy,
   output logic                  o_misaligned
);
   localparam int WORD_W = BITS_ADDR - 2;

   logic [BITS_SIZE-1:0] mem [MEM_DEPTH];
   logic [WORD_W-1:0]    word_idx;
   logic [1:0]           byte_off;
   logic [3:0]           wr_mask;
   logic [BITS_SIZE-1:0] wr_data;
   logic                 ready;
   logic                 clearing;
   logic                 store_req;
   logic [WORD_W-1:0]    clr_cnt;

   // Byte lanes touched by a store; all-zero marks a store that must be rejected.
   function automatic logic [3:0] lane_mask(input logic [BITS_EXTENSION-1:0] sel,
                                            input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      case (sel)
         2'b00:   if (off == 2'b00) m = 4'b1111;
         2'b01:   m = 4'b0001 << off;
         2'b10:   if (!off[0]) m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate the right-justified store data so every enabled lane sees its own bytes.
   function automatic logic [BITS_SIZE-1:0] lane_data(input logic [BITS_EXTENSION-1:0] sel,
                                                      input logic [BITS_SIZE-1:0] data);
      logic [BITS_SIZE-1:0] d;
      case (sel)
         2'b01:   d = {4{data[7:0]}};
         2'b10:   d = {2{data[15:0]}};
         default: d = data;
      endcase
      return d;
   endfunction

   assign word_idx  = i_addr[BITS_ADDR-1:2];
   assign byte_off  = i_addr[1:0];
   assign wr_mask   = lane_mask(i_ctl_select, byte_off);
   assign wr_data   = lane_data(i_ctl_select, i_dato_to_write);
   assign store_req = ready && i_mem_write && !i_reset;

`ifdef DATA_MEMORY_CLEAR_EN
   typedef enum logic {CLEAR, READY} state_t;
   state_t state;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         o_busy  <= 1'b1;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == WORD_W'(MEM_DEPTH - 1)) begin
            state  <= READY;
            o_busy <= 1'b0;
         end
      end
   end

   assign ready    = (state == READY);
   assign clearing = (state == CLEAR) && !i_reset;
`else
   assign ready    = 1'b1;
   assign clearing = 1'b0;
   assign clr_cnt  = '0;
   assign o_busy   = 1'b0;
`endif

   // Array write: clear sweep or lane-masked store; reads below see pre-write contents.
   always_ff @(posedge i_clk) begin
      if (clearing) begin
         mem[clr_cnt] <= '0;
      end else if (store_req) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Registered outputs, one cycle after the request.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_dato_read  <= '0;
         o_debug_dato <= '0;
         o_misaligned <= 1'b0;
      end else begin
         o_debug_dato <= mem[i_debug_addr];
         o_misaligned <= store_req && (wr_mask == 4'b0000);
         if (ready && i_mem_read) o_dato_read <= mem[word_idx];
      end
   end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and randomized checks of data_memory against a byte-level array model.
// Works with or without DATA_MEMORY_CLEAR_EN defined.
module tb_data_memory;
   localparam int BITS_SIZE = 32;
   localparam int BITS_EXTENSION = 2;
   localparam int BITS_ADDR = 8;
   localparam int MEM_DEPTH = 64;

   logic        clk = 1'b0;
   logic        i_reset, i_mem_write, i_mem_read;
   logic [7:0]  i_addr;
   logic [31:0] i_dato_to_write;
   logic [1:0]  i_ctl_select;
   logic [5:0]  i_debug_addr;
   logic [31:0] o_dato_read, o_debug_dato;
   logic        o_busy, o_misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_mem [MEM_DEPTH];
   logic [31:0] exp_rd;

   always #5 clk = ~clk;

   data_memory #(
      .BITS_SIZE(BITS_SIZE), .BITS_EXTENSION(BITS_EXTENSION),
      .BITS_ADDR(BITS_ADDR), .MEM_DEPTH(MEM_DEPTH)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_mem_write(i_mem_write), .i_mem_read(i_mem_read),
      .i_addr(i_addr), .i_dato_to_write(i_dato_to_write), .i_ctl_select(i_ctl_select),
      .i_debug_addr(i_debug_addr), .o_dato_read(o_dato_read), .o_debug_dato(o_debug_dato),
      .o_busy(o_busy), .o_misaligned(o_misaligned)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      i_mem_write = 1'b0;
      i_mem_read = 1'b0;
      i_addr = 8'h00;
      i_dato_to_write = 32'h0;
      i_ctl_select = 2'b00;
   endtask

   function automatic bit store_illegal(input logic [7:0] addr, input logic [1:0] sel);
      int off;
      off = int'(addr) % 4;
      case (sel)
         2'd0:    return off != 0;
         2'd1:    return 1'b0;
         2'd2:    return (off % 2) != 0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int store_bytes(input logic [1:0] sel);
      return (sel == 2'd0) ? 4 : (sel == 2'd1) ? 1 : 2;
   endfunction

   task automatic model_store(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] sel);
      int w, off;
      if (!store_illegal(addr, sel)) begin
         w = int'(addr) / 4;
         off = int'(addr) % 4;
         for (int b = 0; b < store_bytes(sel); b++)
            model_mem[w][8*(off+b) +: 8] = data[8*b +: 8];
      end
   endtask

   task automatic do_store(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] sel,
                           input string tag);
      i_mem_write = 1'b1; i_addr = addr; i_dato_to_write = data; i_ctl_select = sel;
      step();
      i_mem_write = 1'b0;
      check($sformatf("%s_mis", tag), 32'(o_misaligned), 32'(store_illegal(addr, sel)));
      model_store(addr, data, sel);
   endtask

   task automatic do_read(input logic [7:0] addr, input string tag);
      i_mem_read = 1'b1; i_addr = addr;
      step();
      i_mem_read = 1'b0;
      exp_rd = model_mem[addr[7:2]];
      check(tag, o_dato_read, exp_rd);
   endtask

   task automatic sweep(input string tag);
      for (int k = 0; k < MEM_DEPTH; k++) begin
         i_debug_addr = 6'(k);
         step();
         check($sformatf("%s_w%0d", tag, k), o_debug_dato, model_mem[k]);
      end
   endtask

   task automatic count_clear(input string tag);
      int busy_cycles;
      busy_cycles = 0;
      while (o_busy === 1'b1 && busy_cycles < 200) begin
         busy_cycles++;
         drive_idle();
         if (busy_cycles == 10) begin
            i_mem_write = 1'b1; i_mem_read = 1'b1; i_addr = 8'h04;
            i_dato_to_write = 32'hFFFF_FFFF; i_ctl_select = 2'b00;
         end else if (busy_cycles == 12) begin
            i_mem_write = 1'b1; i_addr = 8'h05; i_ctl_select = 2'b11;
         end
         step();
         if (busy_cycles == 10 || busy_cycles == 12) begin
            check($sformatf("%s_busy_mis", tag), 32'(o_misaligned), 32'h0);
            check($sformatf("%s_busy_rd", tag), o_dato_read, 32'h0);
         end
      end
      drive_idle();
      check($sformatf("%s_clear_len", tag), 32'(busy_cycles), 32'd64);
      for (int k = 0; k < MEM_DEPTH; k++) model_mem[k] = 32'h0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic        wr, rd;
      logic [7:0]  addr;
      logic [1:0]  sel;
      logic [31:0] data, exp_dbg;
      logic [5:0]  dbg;
      bit          exp_mis;

      drive_idle();
      i_debug_addr = 6'h0;
      i_reset = 1'b1;
      step();
      exp_rd = 32'h0;
      check("rst_rd", o_dato_read, 32'h0);
      check("rst_dbg", o_debug_dato, 32'h0);
      check("rst_mis", 32'(o_misaligned), 32'h0);
`ifdef DATA_MEMORY_CLEAR_EN
      check("rst_busy", 32'(o_busy), 32'h1);
      i_reset = 1'b0;
      count_clear("first");
`else
      check("rst_busy", 32'(o_busy), 32'h0);
      i_reset = 1'b0;
      for (int k = 0; k < MEM_DEPTH; k++) do_store(8'(k*4), 32'h0, 2'b00, "init");
`endif
      sweep("zero");

      // Word then byte store into the same word
      do_store(8'h10, 32'h1122_3344, 2'b00, "sw10");
      do_store(8'h12, 32'h0000_00AA, 2'b01, "sb12");
      do_read(8'h10, "rd10");
      check("rd10_const", o_dato_read, 32'h11AA_3344);
      step();
      check("rd_hold", o_dato_read, exp_rd);

      // Half stores, aligned and misaligned
      do_store(8'h22, 32'h0000_BEEF, 2'b10, "sh22");
      do_read(8'h20, "rd20");
      check("rd20_const", o_dato_read, 32'hBEEF_0000);
      do_store(8'h21, 32'h0000_1234, 2'b10, "sh21");
      check("sh21_mis_const", 32'(o_misaligned), 32'h1);
      step();
      check("mis_one_cycle", 32'(o_misaligned), 32'h0);
      do_read(8'h20, "rd20b");
      check("rd20b_const", o_dato_read, 32'hBEEF_0000);

      // Invalid selector and misaligned word store
      do_store(8'h14, 32'hCAFE_F00D, 2'b11, "inv14");
      check("inv14_mis_const", 32'(o_misaligned), 32'h1);
      do_store(8'h19, 32'h5555_5555, 2'b00, "sw19");
      do_read(8'h14, "rd14");
      check("rd14_const", o_dato_read, 32'h0);
      do_read(8'h18, "rd18");

      // Simultaneous read and write of the same word
      do_store(8'h30, 32'h1234_5678, 2'b00, "sw30");
      i_mem_write = 1'b1; i_mem_read = 1'b1; i_addr = 8'h30;
      i_dato_to_write = 32'hDEAD_BEEF; i_ctl_select = 2'b00;
      step();
      drive_idle();
      check("rbw_old", o_dato_read, 32'h1234_5678);
      model_store(8'h30, 32'hDEAD_BEEF, 2'b00);
      do_read(8'h33, "rbw_new");
      check("rbw_new_const", o_dato_read, 32'hDEAD_BEEF);

      // Randomized traffic against the array model
      for (int n = 0; n < 400; n++) begin
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         addr = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
         sel = 2'($urandom_range(0, 3));
         data = $urandom;
         if (sel == 2'b01) data = data & 32'h0000_00FF;
         if (sel == 2'b10) data = data & 32'h0000_FFFF;
         dbg = 6'($urandom_range(0, 63));
         i_mem_write = wr; i_mem_read = rd; i_addr = addr;
         i_dato_to_write = data; i_ctl_select = sel; i_debug_addr = dbg;
         if (rd) exp_rd = model_mem[addr[7:2]];
         exp_mis = wr && store_illegal(addr, sel);
         exp_dbg = model_mem[dbg];
         step();
         check("rnd_rd", o_dato_read, exp_rd);
         check("rnd_mis", 32'(o_misaligned), 32'(exp_mis));
         check("rnd_dbg", o_debug_dato, exp_dbg);
         if (wr) model_store(addr, data, sel);
      end
      drive_idle();

      // Reset wins over a simultaneous store and read
      i_reset = 1'b1; i_mem_write = 1'b1; i_mem_read = 1'b1; i_addr = 8'h00;
      i_dato_to_write = 32'hA5A5_A5A5; i_ctl_select = 2'b00;
      step();
      drive_idle();
      exp_rd = 32'h0;
      check("rst2_rd", o_dato_read, 32'h0);
      check("rst2_mis", 32'(o_misaligned), 32'h0);
`ifdef DATA_MEMORY_CLEAR_EN
      check("rst2_busy", 32'(o_busy), 32'h1);
      i_reset = 1'b0;
      for (int c = 1; c < 20; c++) step();
      check("mid_busy", 32'(o_busy), 32'h1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      count_clear("restart");
`else
      check("rst2_busy", 32'(o_busy), 32'h0);
      i_reset = 1'b0;
`endif
      sweep("final");
      do_read(8'h30, "final_rd30");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, data word width.
REQ-002 SHALL have parameter BITS_EXTENSION, default 2, store-size selector width.
REQ-003 SHALL have parameter BITS_ADDR, default 8, byte-address width.
REQ-004 SHALL have parameter MEM_DEPTH, default 64, number of words; equals 2^(BITS_ADDR-2).
REQ-005 SHALL have port i_clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port i_mem_write, input, 1, store request.
REQ-008 SHALL have port i_mem_read, input, 1, load request.
REQ-009 SHALL have port i_addr, input, BITS_ADDR, byte address (base+offset).
REQ-010 SHALL have port i_dato_to_write, input, BITS_SIZE, store data from the store filter, right-justified and zero-extended.
REQ-011 SHALL have port i_ctl_select, input, BITS_EXTENSION: 00 word, 01 byte (SB), 10 half (SH), 11 invalid.
REQ-012 SHALL have port i_debug_addr, input, BITS_ADDR-2, word address for the debug unit.
REQ-013 SHALL have port o_dato_read, output, BITS_SIZE, aligned word read.
REQ-014 SHALL have port o_debug_dato, output, BITS_SIZE, word at i_debug_addr.
REQ-015 SHALL have port o_busy, output, 1, high while clearing.
REQ-016 SHALL have port o_misaligned, output, 1, one-cycle pulse on a rejected store.

Function
REQ-017 Store SHALL write only the byte lanes selected by i_ctl_select and i_addr[1:0]; word index is i_addr[BITS_ADDR-1:2].
REQ-018 Byte store SHALL write i_dato_to_write[7:0] into lane i_addr[1:0]; other three lanes unchanged.
REQ-019 Half store SHALL write i_dato_to_write[15:0] into lanes {1,0} when i_addr[1]=0, or {3,2} when i_addr[1]=1.
REQ-020 Word store SHALL write all four lanes.
REQ-021 Half store with i_addr[0]=1, word store with i_addr[1:0]!=0, or any store with i_ctl_select=11 SHALL be suppressed and SHALL drive o_misaligned=1 for exactly the following cycle.
REQ-022 Read SHALL be registered: o_dato_read updates one cycle after i_mem_read=1 with the full word at i_addr[BITS_ADDR-1:2]; i_addr[1:0] ignored for reads.
REQ-023 o_dato_read SHALL hold its last value while i_mem_read=0.
REQ-024 Read and write of the same word in one cycle SHALL return the pre-write contents (read-before-write).
REQ-025 o_debug_dato SHALL be registered, updated every cycle from i_debug_addr regardless of state or request inputs.
REQ-026 FSM SHALL have two states: CLEAR and READY.
REQ-027 In CLEAR, a word counter starting at 0 SHALL write zero to word[counter] each cycle and increment; at counter=MEM_DEPTH-1 the FSM SHALL move to READY on the next edge (clear takes exactly MEM_DEPTH cycles).
REQ-028 o_busy SHALL be 1 in CLEAR and 0 in READY.
REQ-029 In CLEAR, i_mem_write and i_mem_read SHALL be ignored: no store, no o_misaligned pulse, and o_dato_read is held.
REQ-030 READY SHALL persist until reset.

Reset
REQ-031 On i_reset=1: o_dato_read=0, o_debug_dato=0, o_misaligned=0, counter=0, FSM=CLEAR, o_busy=1 from the cycle after the reset edge.
REQ-032 Reset asserted mid-clear SHALL restart the clear from word 0.
REQ-033 Reset SHALL take priority over every request presented in the same cycle.

Configuration
REQ-034 Macro DATA_MEMORY_CLEAR_EN, when defined, SHALL compile in the CLEAR state and counter as specified.
REQ-035 Without DATA_MEMORY_CLEAR_EN, reset SHALL enter READY directly, o_busy SHALL be constant 0, and memory contents SHALL be left unchanged by reset.

Verification
REQ-036 Reset, then idle (macro on) -> o_busy=1 for 64 cycles then 0; debug sweep of all words reads 0x00000000.
REQ-037 Word store 0x11223344 at addr 0x10, then SB data 0x000000AA at 0x12 -> read at 0x10 returns 0x11AA3344 one cycle after request.
REQ-038 SH data 0x0000BEEF at 0x22 on a zeroed word -> read at 0x20 returns 0xBEEF0000; SH at 0x21 -> o_misaligned=1 for one cycle, word unchanged.
REQ-039 Word store 0xCAFEF00D at 0x14 with i_ctl_select=11 -> o_misaligned pulse, word stays 0; store during o_busy=1 -> ignored, no pulse.
REQ-040 Simultaneous write 0xDEADBEEF and read at 0x30 holding 0x12345678 -> o_dato_read=0x12345678 next cycle, then 0xDEADBEEF on the following read.
REQ-041 Reset asserted at clear cycle 20 -> o_busy remains 1 for 64 further cycles; all words read 0 afterwards.
